mem_arbiter: RTL and testbench

Two-requester arbiter for the processor's single-port synchronous memory. It shares the memory between the CPU datapath, whose requests are driven by the multicycle control FSM's MemRead/MemWrite/IorD path, and one device requester (DMA/IO engine). It uses a req/ack handshake, fixed CPU priority with a bounded starvation guard for the device, and gives the control FSM a stall signal to hold its memory states until the access completes.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory.
// The CPU has fixed priority; a saturating counter bounds how long the device can be starved.
module mem_arbiter #(
  parameter int unsigned DW           = 16,
  parameter int unsigned AW           = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          Clk,
  input  logic          RST,
  input  logic          CpuReq,
  input  logic          CpuWe,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic [DW-1:0] CpuRData,
  output logic          CpuAck,
  output logic          CpuStall,
  input  logic          DevReq,
  input  logic          DevWe,
  input  logic [AW-1:0] DevAddr,
  input  logic [DW-1:0] DevWData,
  output logic [DW-1:0] DevRData,
  output logic          DevAck,
  output logic          DevStall,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic          MemWE,
  output logic          MemRE,
  input  logic [DW-1:0] MemRData,
  output logic          Busy
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DEV = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dev_rdata_q, dev_rdata_d;
  logic          grant_dev;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LIMIT) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dev_rdata_d = dev_rdata_q;
    grant_dev   = 1'b0;
    case (state_q)
      IDLE: begin
        if (CpuReq || DevReq) begin
          // Device wins when alone, or when the CPU has used up its run of grants.
          grant_dev = DevReq && (!CpuReq || (cnt_q == LIMIT));
          owner_d   = grant_dev ? OWN_DEV : OWN_CPU;
          we_d      = grant_dev ? DevWe    : CpuWe;
          addr_d    = grant_dev ? DevAddr  : CpuAddr;
          wdata_d   = grant_dev ? DevWData : CpuWData;
          if (!grant_dev && DevReq) cnt_d = sat_inc(cnt_q);
          else                      cnt_d = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: state_d = CAPTURE;
      CAPTURE: begin
        if (!we_q) begin
          if (owner_q == OWN_DEV) dev_rdata_d = MemRData;
          else                    cpu_rdata_d = MemRData;
        end
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dev_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dev_rdata_q <= dev_rdata_d;
    end
  end

  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign MemRE    = (state_q == ACCESS) && !we_q;
  assign MemWE    = (state_q == ACCESS) && we_q;
  assign CpuAck   = (state_q == ACK) && (owner_q == OWN_CPU);
  assign DevAck   = (state_q == ACK) && (owner_q == OWN_DEV);
  assign CpuStall = CpuReq && !CpuAck;
  assign DevStall = DevReq && !DevAck;
  assign CpuRData = cpu_rdata_q;
  assign DevRData = dev_rdata_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic checked
// against a transaction-level model of arbitration and memory contents.
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        RST;
  logic        CpuReq, CpuWe, DevReq, DevWe;
  logic [15:0] CpuAddr, CpuWData, DevAddr, DevWData;
  logic [15:0] CpuRData, DevRData, MemAddr, MemWData, MemRData;
  logic        CpuAck, CpuStall, DevAck, DevStall, MemWE, MemRE, Busy;

  logic        tb_we;
  logic [15:0] tb_addr, tb_data;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  mem_arbiter #(.DW(16), .AW(16), .STARVE_LIMIT(4)) dut (
    .Clk(Clk), .RST(RST),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuRData(CpuRData), .CpuAck(CpuAck), .CpuStall(CpuStall),
    .DevReq(DevReq), .DevWe(DevWe), .DevAddr(DevAddr), .DevWData(DevWData),
    .DevRData(DevRData), .DevAck(DevAck), .DevStall(DevStall),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRE(MemRE),
    .MemRData(MemRData), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Single-port synchronous memory with a bench backdoor for preloading.
  always @(posedge Clk) begin
    if (tb_we)      mem[tb_addr] <= tb_data;
    else if (MemWE) mem[MemAddr] <= MemWData;
    if (MemRE) MemRData <= mem[MemAddr];
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 37) ^ 16'h5A5A;
  endfunction

  function automatic req_t new_req();
    req_t r;
    r.v    = 1'b1;
    r.we   = 1'($urandom_range(0, 1));
    r.addr = 16'($urandom_range(0, 255));
    r.data = 16'($urandom);
    return r;
  endfunction

  req_t cp, dp, t;
  int   cnt_m;
  bit   win_dev;

  task automatic drive();
    CpuReq = cp.v; CpuWe = cp.we; CpuAddr = cp.addr; CpuWData = cp.data;
    DevReq = dp.v; DevWe = dp.we; DevAddr = dp.addr; DevWData = dp.data;
  endtask

  initial begin
    RST = 1'b1; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    CpuReq = 0; CpuWe = 0; CpuAddr = '0; CpuWData = '0;
    DevReq = 0; DevWe = 0; DevAddr = '0; DevWData = '0;
    // Preload memory while reset is held.
    for (int a = 0; a < 256; a++) begin
      cyc();
      tb_we = 1'b1; tb_addr = 16'(a);
      tb_data = (a == 16) ? 16'hBEEF : init_val(a);
      ref_mem[a] = tb_data;
    end
    cyc(); tb_we = 1'b0;
    cyc(); smp();
    chk1("rst_cpuack", CpuAck, 1'b0);
    chk1("rst_devack", DevAck, 1'b0);
    chk1("rst_memwe", MemWE, 1'b0);
    chk1("rst_memre", MemRE, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chk16("rst_cpurdata", CpuRData, 16'h0);
    chk16("rst_devrdata", DevRData, 16'h0);
    chk16("rst_memaddr", MemAddr, 16'h0);
    chk16("rst_memwdata", MemWData, 16'h0);
    cyc(); RST = 1'b0;

    // CPU read of 0x0010.
    cyc(); CpuReq = 1; CpuWe = 0; CpuAddr = 16'h0010;
    smp(); chk1("rd_c0_stall", CpuStall, 1'b1); chk1("rd_c0_re", MemRE, 1'b0);
    cyc(); smp();
    chk1("rd_c1_re", MemRE, 1'b1); chk1("rd_c1_we", MemWE, 1'b0);
    chk16("rd_c1_addr", MemAddr, 16'h0010); chk1("rd_c1_stall", CpuStall, 1'b1);
    cyc(); smp(); chk1("rd_c2_re", MemRE, 1'b0); chk1("rd_c2_ack", CpuAck, 1'b0);
    chk1("rd_c2_stall", CpuStall, 1'b1);
    cyc(); smp();
    chk1("rd_c3_ack", CpuAck, 1'b1); chk16("rd_c3_data", CpuRData, 16'hBEEF);
    chk1("rd_c3_stall", CpuStall, 1'b0); chk1("rd_c3_re", MemRE, 1'b0);
    cyc(); CpuReq = 0; smp();
    chk1("rd_c4_ack", CpuAck, 1'b0); chk1("rd_c4_busy", Busy, 1'b0);

    // Device write then read of 0x0020.
    cyc(); DevReq = 1; DevWe = 1; DevAddr = 16'h0020; DevWData = 16'h1234;
    cyc(); smp();
    chk1("dw_c1_we", MemWE, 1'b1); chk1("dw_c1_re", MemRE, 1'b0);
    chk16("dw_c1_addr", MemAddr, 16'h0020); chk16("dw_c1_wdata", MemWData, 16'h1234);
    cyc(); smp(); chk1("dw_c2_we", MemWE, 1'b0); chk1("dw_c2_cpuack", CpuAck, 1'b0);
    cyc(); smp(); chk1("dw_c3_ack", DevAck, 1'b1); chk1("dw_c3_cpuack", CpuAck, 1'b0);
    ref_mem[32] = 16'h1234;
    cyc(); DevWe = 0; smp(); chk1("dr_c0_ack", DevAck, 1'b0);
    cyc(); smp(); chk1("dr_c1_re", MemRE, 1'b1); chk1("dr_c1_we", MemWE, 1'b0);
    cyc(); cyc(); smp();
    chk1("dr_c3_ack", DevAck, 1'b1); chk16("dr_c3_data", DevRData, 16'h1234);
    chk1("dr_c3_cpuack", CpuAck, 1'b0);
    cyc(); DevReq = 0;

    // Simultaneous requests: CPU first, device next.
    cyc(); CpuReq = 1; CpuWe = 0; CpuAddr = 16'h0010;
    DevReq = 1; DevWe = 0; DevAddr = 16'h0020;
    cyc(); cyc(); cyc(); smp();
    chk1("sim_c3_cpuack", CpuAck, 1'b1); chk1("sim_c3_devack", DevAck, 1'b0);
    chk1("sim_c3_devstall", DevStall, 1'b1);
    cyc(); CpuReq = 0; smp(); chk1("sim_c4_busy", Busy, 1'b0);
    cyc(); cyc(); cyc(); smp();
    chk1("sim_c7_devack", DevAck, 1'b1); chk1("sim_c7_cpuack", CpuAck, 1'b0);
    chk16("sim_c7_data", DevRData, 16'h1234);
    cyc(); DevReq = 0;

    // Starvation guard: four CPU grants, then the device, repeating.
    cyc(); CpuReq = 1; CpuWe = 0; CpuAddr = 16'h0010; DevReq = 1;
    for (int s = 0; s < 10; s++) begin
      cyc(); cyc(); cyc(); smp();
      chk1("starve_cpuack", CpuAck, (s % 5) != 4);
      chk1("starve_devack", DevAck, (s % 5) == 4);
      cyc();
    end
    CpuReq = 0; DevReq = 0;

    // Reset during CAPTURE of a CPU read, then re-issued read.
    cyc(); CpuReq = 1; CpuWe = 0; CpuAddr = 16'h0020;
    cyc(); cyc(); RST = 1; smp(); chk1("rstc_c2_busy", Busy, 1'b1);
    cyc(); RST = 0; smp();
    chk1("rstc_ack", CpuAck, 1'b0); chk1("rstc_busy", Busy, 1'b0);
    chk1("rstc_re", MemRE, 1'b0); chk1("rstc_we", MemWE, 1'b0);
    chk16("rstc_cpurdata", CpuRData, 16'h0); chk16("rstc_devrdata", DevRData, 16'h0);
    chk16("rstc_memaddr", MemAddr, 16'h0); chk16("rstc_memwdata", MemWData, 16'h0);
    cyc(); cyc(); cyc(); smp();
    chk1("rstc_reissue_ack", CpuAck, 1'b1); chk16("rstc_reissue_data", CpuRData, 16'h1234);
    cyc(); CpuReq = 0;

    // Device request arriving during the ACK cycle of a CPU write.
    cyc(); CpuReq = 1; CpuWe = 1; CpuAddr = 16'h0030; CpuWData = 16'hCAFE;
    cyc(); cyc(); cyc(); DevReq = 1; DevWe = 0; DevAddr = 16'h0030; smp();
    chk1("late_c3_cpuack", CpuAck, 1'b1); chk1("late_c3_re", MemRE, 1'b0);
    chk1("late_c3_we", MemWE, 1'b0); chk1("late_c3_devack", DevAck, 1'b0);
    ref_mem[48] = 16'hCAFE;
    cyc(); CpuReq = 0; smp(); chk1("late_c4_busy", Busy, 1'b0); chk1("late_c4_re", MemRE, 1'b0);
    cyc(); smp(); chk1("late_c5_re", MemRE, 1'b1); chk16("late_c5_addr", MemAddr, 16'h0030);
    cyc(); cyc(); smp();
    chk1("late_c7_devack", DevAck, 1'b1); chk16("late_c7_data", DevRData, 16'hCAFE);
    cyc(); DevReq = 0;

    // Random traffic against the transaction-level model.
    cyc(); RST = 1; cyc(); RST = 0;
    cp = '0; dp = '0; cnt_m = 0;
    for (int it = 0; it < 200; it++) begin
      if (!cp.v && $urandom_range(0, 2) == 0) cp = new_req();
      if (!dp.v && $urandom_range(0, 2) == 0) dp = new_req();
      drive();
      smp(); chk1("rnd_idle_busy", Busy, 1'b0);
      if (!cp.v && !dp.v) begin
        cyc();
        continue;
      end
      win_dev = dp.v && (!cp.v || cnt_m == 4);
      if (win_dev)   cnt_m = 0;
      else if (dp.v) cnt_m = (cnt_m < 4) ? cnt_m + 1 : 4;
      else           cnt_m = 0;
      t = win_dev ? dp : cp;
      cyc();
      if (win_dev && !cp.v && $urandom_range(0, 1) == 1) cp = new_req();
      if (!win_dev && !dp.v && $urandom_range(0, 1) == 1) dp = new_req();
      drive();
      if ($urandom_range(0, 1) == 1) begin
        if (win_dev) begin DevAddr = ~t.addr; DevWData = ~t.data; DevWe = ~t.we; end
        else         begin CpuAddr = ~t.addr; CpuWData = ~t.data; CpuWe = ~t.we; end
      end
      smp();
      chk1("rnd_c1_re", MemRE, !t.we); chk1("rnd_c1_we", MemWE, t.we);
      chk16("rnd_c1_addr", MemAddr, t.addr);
      if (t.we) chk16("rnd_c1_wdata", MemWData, t.data);
      cyc(); smp();
      chk1("rnd_c2_re", MemRE, 1'b0); chk1("rnd_c2_we", MemWE, 1'b0);
      cyc(); smp();
      chk1("rnd_c3_cpuack", CpuAck, !win_dev); chk1("rnd_c3_devack", DevAck, win_dev);
      chk1("rnd_c3_cpustall", CpuStall, cp.v && win_dev);
      if (t.we) ref_mem[t.addr[7:0]] = t.data;
      else if (win_dev) chk16("rnd_dev_rdata", DevRData, ref_mem[t.addr[7:0]]);
      else              chk16("rnd_cpu_rdata", CpuRData, ref_mem[t.addr[7:0]]);
      if (win_dev) dp = ($urandom_range(0, 9) < 6) ? new_req() : '0;
      else         cp = ($urandom_range(0, 9) < 6) ? new_req() : '0;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
